mem_responder: RTL and testbench
================================

# mem_responder

- Memory-side responder for the `cpu` core. It serves the instruction port (`pc` → `instr`) and the data port (`data_addr`/`data_out`/`mem_write_en` → `data_in`) from one external single-port synchronous SRAM plus a small MMIO register bank.
- Once per CPU step (`clk_stb_800k`), a sequencer performs the fetch, then the dependent data access, so `instr` and `data_in` are stable before the CPU's next commit strobe.
- Sits between `cpu` and the board SRAM/LED pins in the top level.

## Interface

Parameters:
- `MMIO_BASE`, 16'hF800: addresses ≥ this decode to MMIO; below go to SRAM. The stack starts at F7FF.
- `LED_ADDR`, 16'hFFF0: read/write LED register.
- `CNT_ADDR`, 16'hFFF1: read-only step counter.

Ports:
- `clk`  in  1  system clock; the design's only clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `clk_stb_800k`  in  1  one-cycle CPU step strobe, the same signal `cpu` uses.
- `pc`  in  16  instruction address from `cpu`.
- `instr`  out  16  registered instruction word to `cpu`.
- `data_addr`  in  16  data address from `cpu`, combinational from `instr`.
- `data_out`  in  16  store data from `cpu`.
- `mem_write_en`  in  1  store request from `cpu`.
- `data_in`  out  16  registered load data to `cpu`.
- `sram_addr`  out  16  SRAM address.
- `sram_wdata`  out  16  SRAM write data.
- `sram_we`  out  1  SRAM write enable, one cycle.
- `sram_rdata`  in  16  SRAM read data; valid the cycle after the address edge.
- `leds`  out  16  LED register.
- `overrun`  out  1  sticky error flag: a strobe arrived before the sequence completed.

## Operation

- FSM states: IDLE, FETCH, FETCH_WAIT, DATA, DATA_WAIT, DONE.
- Reset values:
  - state IDLE.
  - `instr` = 16'hFFFF (the reset instruction, a nop).
  - `data_in` = 0, `leds` = 0, step counter = 0, `overrun` = 0.
  - `sram_we` = 0, `sram_addr` = 0, `sram_wdata` = 0.
- IDLE/DONE + strobe → FETCH; the counter increments (16-bit wrap).
- FETCH: `sram_addr` = `pc`, `sram_we` = 0 → FETCH_WAIT.
- FETCH_WAIT: capture `sram_rdata` into `instr` → DATA.
- DATA, by the `data_addr` decode:
  - RAM store (`data_addr` < MMIO_BASE, `mem_write_en`): `sram_addr` = `data_addr`, `sram_wdata` = `data_out`, `sram_we` = 1 for exactly this cycle.
  - RAM read: `sram_addr` = `data_addr`, `sram_we` = 0.
  - MMIO write to LED_ADDR: update `leds` at the DATA exit edge.
  - Other MMIO writes: ignored, never reach the SRAM.
  - Next state DATA_WAIT.
- DATA_WAIT: load `data_in`:
  - RAM address: `sram_rdata`.
  - LED_ADDR: `leds`.
  - CNT_ADDR: the counter.
  - Other MMIO: 0.
  - Next state DONE.
- The data read is performed every step, whether or not the CPU uses it. Writes occur at most once per step.
- A strobe seen in FETCH..DATA_WAIT:
  - set `overrun`, which stays set until reset;
  - restart at FETCH; no further writes are issued from the aborted step.
- MMIO addresses never drive `sram_we`. `sram_addr` never exceeds 16'hF7FF during a data access.
- Reset asserted mid-sequence: immediately return to reset values. A pending write is dropped.

## Timing

- Strobe sampled at edge k:
  - FETCH during k..k+1;
  - `instr` valid from edge k+2;
  - DATA during k+2..k+3; the SRAM write commits at edge k+3;
  - `data_in` valid from edge k+4;
  - DONE from k+4.
- Minimum legal strobe spacing is 5 cycles. The 800 kHz strobe from the board clock far exceeds this.
- After reset release: `instr` = FFFF until the first strobe's fetch completes at k+2.

## Structure

- `defs.vh` gains `MMIO_BASE`, `LED_ADDR`, `CNT_ADDR` and the state encodings as localparams, alongside `WORD_WIDTH`.
- One sub-module, `mmio_regs`, holds the LED register and the step counter, with write-enable/address/read-mux ports.
- The FSM and the SRAM muxing live in `mem_responder`.

## Test plan

- Reset, then strobe; SRAM[0]=16'h1234 → `instr` = 1234 at k+2, `sram_we` never high.
- SRAM store: `data_addr`=16'h0100, `data_out`=16'hBEEF, `mem_write_en`=1 → `sram_we` high exactly at cycle k+2..k+3 with addr 0100, data BEEF.
- Read back: the next step with `data_addr`=0100 → `data_in` = BEEF at k+4.
- MMIO:
  - write to FFF0 of 16'h00A5 → `leds` = 00A5, no SRAM write;
  - read of FFF1 after 3 strobes → 3;
  - read of F900 → 0.
- Strobes 3 cycles apart → `overrun` = 1 and stays 1. Reset mid-DATA with a store pending → no `sram_we` pulse, all outputs at reset values.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types, address map defaults, sequencer state encodings and the
// data-address decoder for the CPU memory responder.
package mem_responder_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // The stack grows down from F7FF, so everything from F800 up is MMIO.
    localparam word_t MMIO_BASE_DEFAULT = 16'hF800;
    localparam word_t LED_ADDR_DEFAULT  = 16'hFFF0;
    localparam word_t CNT_ADDR_DEFAULT  = 16'hFFF1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd2;
    localparam logic [2:0] ST_DATA       = 3'd3;
    localparam logic [2:0] ST_DATA_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_LED,
        REGION_CNT,
        REGION_MMIO
    } region_e;

    function automatic region_e decode_addr(
        input word_t addr,
        input word_t mmio_base,
        input word_t led_addr,
        input word_t cnt_addr
    );
        if (addr < mmio_base) return REGION_RAM;
        if (addr == led_addr) return REGION_LED;
        if (addr == cnt_addr) return REGION_CNT;
        return REGION_MMIO;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side instruction/data ports and board SRAM port served by mem_responder.
interface mem_responder_if;
    import mem_responder_pkg::*;

    word_t pc;
    word_t instr;
    word_t data_addr;
    word_t data_out;
    logic  mem_write_en;
    word_t data_in;

    word_t sram_addr;
    word_t sram_wdata;
    logic  sram_we;
    word_t sram_rdata;

    // Responder view.
    modport slave (
        input  pc, data_addr, data_out, mem_write_en, sram_rdata,
        output instr, data_in, sram_addr, sram_wdata, sram_we
    );

    // CPU plus SRAM view, as seen from the rest of the top level.
    modport master (
        output pc, data_addr, data_out, mem_write_en, sram_rdata,
        input  instr, data_in, sram_addr, sram_wdata, sram_we
    );

endinterface

// File: rtl/mem_responder_mmio_regs.sv
// MMIO register bank: the read/write LED register and the read-only CPU
// step counter, with a combinational read mux on the data address.
module mmio_regs
    import mem_responder_pkg::*;
#(
    parameter word_t LED_ADDR = LED_ADDR_DEFAULT,
    parameter word_t CNT_ADDR = CNT_ADDR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  step,
    input  logic  wr_en,
    input  word_t addr,
    input  word_t wdata,
    output word_t leds,
    output word_t rdata
);

    word_t step_cnt;

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds     <= '0;
            step_cnt <= '0;
        end else begin
            if (step) begin
                step_cnt <= step_cnt + 16'd1;
            end
            if (wr_en && (addr == LED_ADDR)) begin
                leds <= wdata;
            end
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        rdata = '0;
        if (addr == LED_ADDR) begin
            rdata = leds;
        end else if (addr == CNT_ADDR) begin
            rdata = step_cnt;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Per-step fetch-then-data sequencer serving the CPU from one synchronous
// single-port SRAM plus the MMIO register bank.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter word_t MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter word_t LED_ADDR  = LED_ADDR_DEFAULT,
    parameter word_t CNT_ADDR  = CNT_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_stb_800k,
    mem_responder_if.slave  bus,
    output word_t           leds,
    output logic            overrun
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    region_e    region;
    logic       busy;
    logic       store_now;
    logic       mmio_wr;
    word_t      mmio_rdata;

    assign region = decode_addr(bus.data_addr, MMIO_BASE, LED_ADDR, CNT_ADDR);
    assign busy   = (state == ST_FETCH) || (state == ST_FETCH_WAIT) ||
                    (state == ST_DATA)  || (state == ST_DATA_WAIT);

    // A strobe landing on the DATA exit edge aborts the step, so its store is withheld.
    assign store_now = (state == ST_DATA) && bus.mem_write_en && !clk_stb_800k;
    assign mmio_wr   = store_now && (region != REGION_RAM);

    // ---------------------------------------------------------------------
    // Sequencer: any strobe (re)starts at FETCH.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (clk_stb_800k) begin
            state_nxt = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:      state_nxt = ST_FETCH_WAIT;
                ST_FETCH_WAIT: state_nxt = ST_DATA;
                ST_DATA:       state_nxt = ST_DATA_WAIT;
                ST_DATA_WAIT:  state_nxt = ST_DONE;
                default:       state_nxt = state;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // SRAM port: combinational so the DATA-cycle address follows the freshly
    // captured instruction; MMIO addresses never reach the SRAM.
    // ---------------------------------------------------------------------
    always_comb begin
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        bus.sram_we    = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.sram_addr = bus.pc;
            end
            ST_DATA: begin
                if (region == REGION_RAM) begin
                    bus.sram_addr  = bus.data_addr;
                    bus.sram_wdata = bus.data_out;
                    bus.sram_we    = store_now;
                end
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs to the CPU and the sticky overrun flag.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bus.instr   <= 16'hFFFF;
            bus.data_in <= '0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clk_stb_800k && busy) begin
                overrun <= 1'b1;
            end
            if ((state == ST_FETCH_WAIT) && !clk_stb_800k) begin
                bus.instr <= bus.sram_rdata;
            end
            if ((state == ST_DATA_WAIT) && !clk_stb_800k) begin
                bus.data_in <= (region == REGION_RAM) ? bus.sram_rdata : mmio_rdata;
            end
        end
    end

    mmio_regs #(
        .LED_ADDR (LED_ADDR),
        .CNT_ADDR (CNT_ADDR)
    ) u_mmio_regs (
        .clk   (clk),
        .rst   (rst),
        .step  (clk_stb_800k),
        .wr_en (mmio_wr),
        .addr  (bus.data_addr),
        .wdata (bus.data_out),
        .leds  (leds),
        .rdata (mmio_rdata)
    );

    // ---------------------------------------------------------------------
    // Safety properties of the SRAM port and the error flag.
    // ---------------------------------------------------------------------
    a_we_only_ram_data: assert property (@(posedge clk) disable iff (!rst)
        bus.sram_we |-> ((state == ST_DATA) && (bus.sram_addr < MMIO_BASE)));

    a_overrun_sticky: assert property (@(posedge clk) disable iff (!rst)
        overrun |=> overrun);

    a_fetch_after_strobe: assert property (@(posedge clk) disable iff (!rst)
        clk_stb_800k |=> (state == ST_FETCH));

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a step-level memory/MMIO model queues the
// expected outcome of each CPU step; a monitor checks each step as it completes.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam word_t T_MMIO_BASE = 16'hF800;
    localparam word_t T_LED       = 16'hFFF0;
    localparam word_t T_CNT       = 16'hFFF1;

    typedef struct {
        word_t instr_prev;
        word_t instr;
        word_t data_in;
        word_t leds;
        bit    wr;
        word_t wa;
        word_t wd;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  stb = 1'b0;
    word_t leds;
    logic  overrun;
    bit    mon_en = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t  sb_q[$];
    word_t env_mem [0:65535];
    word_t ref_mem [0:65535];
    word_t ref_instr;
    word_t ref_leds;
    word_t ref_cnt;

    mem_responder_if bus();

    mem_responder #(
        .MMIO_BASE (T_MMIO_BASE),
        .LED_ADDR  (T_LED),
        .CNT_ADDR  (T_CNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_stb_800k (stb),
        .bus          (bus.slave),
        .leds         (leds),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic word_t init_val(input word_t a);
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    // Board SRAM: synchronous, one-cycle read latency, read-before-write.
    initial begin
        for (int i = 0; i < 65536; i++) env_mem[i] = init_val(word_t'(i));
    end

    always @(posedge clk) begin
        bus.sram_rdata <= env_mem[bus.sram_addr];
        if (bus.sram_we) env_mem[bus.sram_addr] <= bus.sram_wdata;
    end

    task automatic check(input string name, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Step-level reference: fetch precedes the data access, loads see memory
    // before this step's store, MMIO reads see this step's LED write and count.
    task automatic step(input word_t pc, input word_t daddr, input word_t dout, input bit we);
        exp_t e;
        ref_cnt      = ref_cnt + 16'd1;
        e.instr_prev = ref_instr;
        e.instr      = ref_mem[pc];
        ref_instr    = e.instr;
        e.wr = 1'b0;
        e.wa = '0;
        e.wd = '0;
        if (daddr < T_MMIO_BASE) begin
            e.data_in = ref_mem[daddr];
            if (we) begin
                ref_mem[daddr] = dout;
                e.wr = 1'b1;
                e.wa = daddr;
                e.wd = dout;
            end
        end else begin
            if (we && daddr == T_LED) ref_leds = dout;
            e.data_in = (daddr == T_LED) ? ref_leds : (daddr == T_CNT) ? ref_cnt : 16'h0000;
        end
        e.leds = ref_leds;
        sb_q.push_back(e);

        bus.pc           = pc;
        bus.data_addr    = daddr;
        bus.data_out     = dout;
        bus.mem_write_en = we;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: follows each accepted strobe through its five-cycle step.
    task automatic watch_step();
        exp_t  e;
        int    nwe = 0;
        int    we_slot = 0;
        word_t wa = '0;
        word_t wd = '0;
        word_t got_prev = '0;
        word_t got_instr = '0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (bus.sram_we) begin
                nwe++;
                we_slot = n;
                wa = bus.sram_addr;
                wd = bus.sram_wdata;
            end
            if (n == 2) got_prev = bus.instr;
            if (n == 3) got_instr = bus.instr;
        end
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            check("instr_held", got_prev, e.instr_prev);
            check("instr", got_instr, e.instr);
            check("data_in", bus.data_in, e.data_in);
            check("leds", leds, e.leds);
            check("we_pulses", word_t'(nwe), word_t'(e.wr));
            if (e.wr) begin
                check("we_slot", word_t'(we_slot), 16'd3);
                check("we_addr", wa, e.wa);
                check("we_data", wd, e.wd);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (stb && rst && mon_en) watch_step();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, bus.instr, 16'hFFFF);
        check({tag, "_data_in"}, bus.data_in, 16'h0000);
        check({tag, "_leds"}, leds, 16'h0000);
        check({tag, "_overrun"}, word_t'(overrun), 16'h0000);
        check({tag, "_sram_we"}, word_t'(bus.sram_we), 16'h0000);
        check({tag, "_sram_addr"}, bus.sram_addr, 16'h0000);
        check({tag, "_sram_wdata"}, bus.sram_wdata, 16'h0000);
    endtask

    initial begin
        word_t pc;
        word_t da;
        word_t kept;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(word_t'(i));
        ref_instr = 16'hFFFF;
        ref_leds  = '0;
        ref_cnt   = '0;
        bus.pc = '0;
        bus.data_addr = '0;
        bus.data_out = '0;
        bus.mem_write_en = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed steps: fetch of 1234, store/readback, MMIO, boundaries.
        step(16'h0000, 16'h0200, 16'h0000, 1'b0);
        step(16'h0001, 16'h0100, 16'hBEEF, 1'b1);
        step(16'h0002, T_CNT,    16'h0000, 1'b0);
        step(16'h0003, 16'h0100, 16'h0000, 1'b0);
        step(16'h0004, T_LED,    16'h00A5, 1'b1);
        step(16'h0005, T_LED,    16'h0000, 1'b0);
        step(16'h0006, 16'hF900, 16'h0000, 1'b0);
        step(16'h0007, 16'hF900, 16'h1111, 1'b1);
        step(16'h0008, 16'hF7FF, 16'h7777, 1'b1);
        step(16'h0009, T_MMIO_BASE, 16'h8888, 1'b1);
        step(16'h0100, 16'hF7FF, 16'h0000, 1'b0);

        // Random steps over a small RAM window, the MMIO edge and the registers.
        for (int i = 0; i < 40; i++) begin
            pc = 16'h0100 + word_t'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: da = 16'h0100 + word_t'($urandom_range(0, 7));
                1: da = 16'hF7F8 + word_t'($urandom_range(0, 7));
                2: da = ($urandom_range(0, 1) != 0) ? T_LED : T_CNT;
                default: da = T_MMIO_BASE + word_t'($urandom_range(0, 16'h07FF));
            endcase
            step(pc, da, word_t'($urandom), $urandom_range(0, 1) != 0);
        end

        // Strobes three cycles apart set the sticky overrun flag.
        mon_en = 1'b0;
        bus.pc = 16'h0020;
        bus.data_addr = 16'h0200;
        bus.mem_write_en = 1'b0;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("overrun_before", word_t'(overrun), 16'h0000);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("overrun_set", word_t'(overrun), 16'h0001);
        repeat (20) @(negedge clk);
        check("overrun_sticky", word_t'(overrun), 16'h0001);

        // Reset in the DATA cycle of a pending store drops the store.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ref_instr = 16'hFFFF;
        ref_leds  = '0;
        ref_cnt   = '0;
        kept = ref_mem[16'h0300];
        bus.pc = 16'h0010;
        bus.data_addr = 16'h0300;
        bus.data_out = 16'hCAFE;
        bus.mem_write_en = 1'b1;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("store_pending", word_t'(bus.sram_we), 16'h0001);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("store_dropped", env_mem[16'h0300], kept);

        mon_en = 1'b1;
        step(16'h0011, T_CNT, 16'h0000, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_empty", word_t'(sb_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
